// File: rtl/fe_pattern_match.sv
// fe_pattern_match: masked multi-byte trigger on the fe_capture pattern-match byte stream.
// Arms from an asynchronous level, fires once per arm, then holds capture enable until fe_capture stops.
module fe_pattern_match #(
  parameter int pBYTES       = 8,
  parameter int pDELAY_WIDTH = 20
) (
  input  logic                    fe_clk,
  input  logic                    reset_n,
  input  logic [7:0]              I_pm_data,
  input  logic                    I_pm_wr,
  input  logic [8*pBYTES-1:0]     I_pattern,
  input  logic [8*pBYTES-1:0]     I_mask,
  input  logic [3:0]              I_pattern_bytes,
  input  logic [pDELAY_WIDTH-1:0] I_trigger_delay,
  input  logic                    I_arm,
  input  logic                    I_capturing,
  output logic                    O_capture_enable,
  output logic                    O_match,
  output logic [2:0]              O_state
);

  // state   | meaning
  // IDLE    | disarmed, waiting for arm rising edge
  // ARMED   | searching the byte stream for the pattern
  // DELAY   | match seen, counting down the trigger delay
  // CAPTURE | capture enable asserted until fe_capture stops
  // DONE    | capture finished, holding until disarm
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    DELAY   = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int            CW        = $clog2(pBYTES + 1);
  localparam logic [CW-1:0] BYTES_MAX = CW'(pBYTES);

  (* ASYNC_REG = "TRUE" *) logic arm_meta;
  (* ASYNC_REG = "TRUE" *) logic arm_s;
  logic arm_d;
  logic arm_rise;

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_meta <= 1'b0;
      arm_s    <= 1'b0;
      arm_d    <= 1'b0;
    end else begin
      arm_meta <= I_arm;
      arm_s    <= arm_meta;
      arm_d    <= arm_s;
    end
  end

  assign arm_rise = arm_s & ~arm_d;

  // Quasi-static configuration, only changed by software while disarmed
  logic [8*pBYTES-1:0]     pat_r;
  logic [8*pBYTES-1:0]     mask_r;
  logic [CW-1:0]           nbytes_r;
  logic [pDELAY_WIDTH-1:0] delay_r;
  logic [CW-1:0]           nbytes_c;

  assign nbytes_c = (I_pattern_bytes > 4'(pBYTES)) ? BYTES_MAX : CW'(I_pattern_bytes);

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_r    <= '0;
      mask_r   <= '0;
      nbytes_r <= '0;
      delay_r  <= '0;
    end else begin
      pat_r    <= I_pattern;
      mask_r   <= I_mask;
      nbytes_r <= nbytes_c;
      delay_r  <= I_trigger_delay;
    end
  end

  logic [8*pBYTES-1:0] sr;
  logic [CW-1:0]       byte_cnt;
  logic                new_r;

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      sr       <= '0;
      byte_cnt <= '0;
      new_r    <= 1'b0;
    end else begin
      new_r <= I_pm_wr;
      if (arm_rise) begin
        sr       <= '0;
        byte_cnt <= '0;
      end else if (I_pm_wr) begin
        sr <= {sr[8*pBYTES-9:0], I_pm_data};
        if (byte_cnt != BYTES_MAX)
          byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

  // Byte 0 of sr is the most recent byte, lined up with byte 0 of the pattern
  logic hit;

  always_comb begin
    hit = (byte_cnt >= nbytes_r);
    for (int i = 0; i < pBYTES; i++) begin
      if ((i < int'(nbytes_r)) &&
          (((sr[8*i +: 8] ^ pat_r[8*i +: 8]) & mask_r[8*i +: 8]) != 8'h00))
        hit = 1'b0;
    end
  end

  state_t                  state;
  logic [pDELAY_WIDTH-1:0] dly_cnt;

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      dly_cnt          <= '0;
      O_match          <= 1'b0;
      O_capture_enable <= 1'b0;
    end else begin
      O_match <= 1'b0;
      if (!arm_s) begin
        state            <= IDLE;
        O_capture_enable <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (arm_rise)
              state <= ARMED;
          end
          ARMED: begin
            if ((nbytes_r == '0) || (new_r && hit)) begin
              O_match <= 1'b1;
              dly_cnt <= delay_r;
              if (delay_r == '0) begin
                state            <= CAPTURE;
                O_capture_enable <= 1'b1;
              end else begin
                state <= DELAY;
              end
            end
          end
          DELAY: begin
            if (dly_cnt == pDELAY_WIDTH'(1)) begin
              state            <= CAPTURE;
              O_capture_enable <= 1'b1;
            end else begin
              dly_cnt <= dly_cnt - 1'b1;
            end
          end
          CAPTURE: begin
            if (!I_capturing) begin
              state            <= DONE;
              O_capture_enable <= 1'b0;
            end
          end
          DONE: begin
            state <= DONE;
          end
          default: begin
            state            <= IDLE;
            O_capture_enable <= 1'b0;
          end
        endcase
      end
    end
  end

  assign O_state = state;

endmodule
